// File: rtl/axi_lite_rom_rd.sv
// AXI4-Lite read-only front end for a fixed-latency synchronous ROM.
// Reads go through a three-state FSM that drives a registered word address
// to the ROM and waits ROM_LATENCY cycles for its data. Writes are accepted
// and discarded, and every write gets a SLVERR response.
// DATA_WIDTH must be 32 or 64. ROM_LATENCY must be in the range 1 to 4.

module axi_lite_rom_rd #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int ROM_ADDR_WIDTH = ADDR_WIDTH - $clog2(DATA_WIDTH / 8),
    parameter int ROM_LATENCY    = 1
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr_i,
    input  logic                      s_axi_arvalid_i,
    output logic                      s_axi_arready_o,
    // read data channel
    output logic [DATA_WIDTH-1:0]     s_axi_rdata_o,
    output logic [1:0]                s_axi_rresp_o,
    output logic                      s_axi_rvalid_o,
    input  logic                      s_axi_rready_i,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr_i,
    input  logic                      s_axi_awvalid_i,
    output logic                      s_axi_awready_o,
    // write data channel
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb_i,
    input  logic                      s_axi_wvalid_i,
    output logic                      s_axi_wready_o,
    // write response channel
    output logic [1:0]                s_axi_bresp_o,
    output logic                      s_axi_bvalid_o,
    input  logic                      s_axi_bready_i,
    // ROM port
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0]     rom_data_i
);

    localparam int OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int CNT_W = $clog2(ROM_LATENCY + 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_RESP
    } rd_state_t;

    rd_state_t         rd_state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              aw_done;
    logic              w_done;

    // Write beats that have been captured, including beats accepted this cycle.
    logic aw_hs;
    logic w_hs;
    logic aw_captured;
    logic w_captured;

    // NOTE: write payloads and the byte-offset address bits are unused on purpose.
    // Collecting them into one "unused" net keeps lint quiet without tool directives.
    logic unused_write_bits;
    assign unused_write_bits = ^{s_axi_awaddr_i, s_axi_wdata_i, s_axi_wstrb_i,
                                 s_axi_araddr_i[OFF_W-1:0]};

    // Every read completes with OKAY.
    assign s_axi_rresp_o = RESP_OKAY;

    assign aw_hs       = s_axi_awvalid_i & s_axi_awready_o;
    assign w_hs        = s_axi_wvalid_i  & s_axi_wready_o;
    assign aw_captured = aw_done | aw_hs;
    assign w_captured  = w_done  | w_hs;

    // Read FSM: accept the address, wait out the ROM latency, then hold the beat until rready.
    // NOTE: the reset branch is synchronous and sits inside the clocked block.
    // All state uses non-blocking assignments, so every register sees the values from before the edge.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rd_state        <= RD_IDLE;
            wait_cnt        <= '0;
            rom_addr_o      <= '0;
            s_axi_arready_o <= 1'b0;
            s_axi_rvalid_o  <= 1'b0;
            s_axi_rdata_o   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    s_axi_arready_o <= 1'b1;
                    if (s_axi_arready_o && s_axi_arvalid_i) begin
                        s_axi_arready_o <= 1'b0;
                        rom_addr_o      <= ROM_ADDR_WIDTH'(s_axi_araddr_i[ADDR_WIDTH-1:OFF_W]);
                        wait_cnt        <= CNT_W'(ROM_LATENCY);
                        rd_state        <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        s_axi_rdata_o  <= rom_data_i;
                        s_axi_rvalid_o <= 1'b1;
                        rd_state       <= RD_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RD_RESP: begin
                    if (s_axi_rready_i) begin
                        s_axi_rvalid_o  <= 1'b0;
                        s_axi_arready_o <= 1'b1;
                        rd_state        <= RD_IDLE;
                    end
                end
                default: begin
                    rd_state        <= RD_IDLE;
                    s_axi_arready_o <= 1'b0;
                    s_axi_rvalid_o  <= 1'b0;
                end
            endcase
        end
    end

    // Write sink: capture AW and W in either order, answer SLVERR, and clear once bready is seen.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            s_axi_awready_o <= 1'b0;
            s_axi_wready_o  <= 1'b0;
            s_axi_bvalid_o  <= 1'b0;
            s_axi_bresp_o   <= '0;
        end else if (s_axi_bvalid_o) begin
            if (s_axi_bready_i) begin
                aw_done         <= 1'b0;
                w_done          <= 1'b0;
                s_axi_awready_o <= 1'b1;
                s_axi_wready_o  <= 1'b1;
                s_axi_bvalid_o  <= 1'b0;
                s_axi_bresp_o   <= '0;
            end
        end else begin
            aw_done         <= aw_captured;
            w_done          <= w_captured;
            s_axi_awready_o <= ~aw_captured;
            s_axi_wready_o  <= ~w_captured;
            if (aw_captured && w_captured) begin
                s_axi_bvalid_o <= 1'b1;
                s_axi_bresp_o  <= RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_rom_rd.sv
// Directed bench for axi_lite_rom_rd.
// One instance uses the default ROM latency and carries most of the tests.
// A second instance uses ROM_LATENCY=3 and checks the longer read latency.
// Each ROM model is a registered pipeline holding mem[i] = i * 0x11111111.

module tb_axi_lite_rom_rd;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    // instance with ROM_LATENCY = 1
    logic [11:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [11:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;

    // instance with ROM_LATENCY = 3 (the write channel is held idle)
    logic [11:0] araddr3;
    logic        arvalid3, arready3;
    logic [31:0] rdata3;
    logic [1:0]  rresp3;
    logic        rvalid3, rready3;
    logic        awready3, wready3, bvalid3;
    logic [1:0]  bresp3;
    logic [9:0]  rom_addr3;
    logic [31:0] rom_data3;

    axi_lite_rom_rd #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .ROM_LATENCY(1)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
        .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rvalid_o(rvalid),
        .s_axi_rready_i(rready),
        .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
        .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid),
        .s_axi_wready_o(wready),
        .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data)
    );

    axi_lite_rom_rd #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .ROM_LATENCY(3)) dut3 (
        .clk_i(clk), .rstn_i(rstn),
        .s_axi_araddr_i(araddr3), .s_axi_arvalid_i(arvalid3), .s_axi_arready_o(arready3),
        .s_axi_rdata_o(rdata3), .s_axi_rresp_o(rresp3), .s_axi_rvalid_o(rvalid3),
        .s_axi_rready_i(rready3),
        .s_axi_awaddr_i(12'h000), .s_axi_awvalid_i(1'b0), .s_axi_awready_o(awready3),
        .s_axi_wdata_i(32'h0), .s_axi_wstrb_i(4'h0), .s_axi_wvalid_i(1'b0),
        .s_axi_wready_o(wready3),
        .s_axi_bresp_o(bresp3), .s_axi_bvalid_o(bvalid3), .s_axi_bready_i(1'b0),
        .rom_addr_o(rom_addr3), .rom_data_i(rom_data3)
    );

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        logic [31:0] w;
        w = {22'b0, a};
        return w * 32'h1111_1111;
    endfunction

    // latency-1 ROM
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    // latency-3 ROM
    logic [31:0] rom3_pipe [3];
    always @(posedge clk) begin
        rom3_pipe[0] <= rom_word(rom_addr3);
        rom3_pipe[1] <= rom3_pipe[0];
        rom3_pipe[2] <= rom3_pipe[1];
    end
    assign rom_data3 = rom3_pipe[2];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_arready(input string tag);
        int n;
        n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        check({tag, " arready before AR"}, arready, 1'b1);
    endtask

    // A full read on the latency-1 instance, with latency and data checks.
    task automatic do_read(input logic [11:0] addr, input logic [9:0] exp_idx,
                           input logic [31:0] exp_data, input string tag);
        int n;
        wait_arready(tag);
        araddr  = addr;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        araddr  = '0;
        check({tag, " rom_addr"}, rom_addr, exp_idx);
        check({tag, " arready low in WAIT"}, arready, 1'b0);
        n = 0;
        while (!rvalid && n < 10) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, 2);
        check({tag, " rdata"}, rdata, exp_data);
        check({tag, " rresp"}, rresp, 2'b00);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check({tag, " rvalid after R hs"}, rvalid, 1'b0);
        tick();
        check({tag, " arready back"}, arready, 1'b1);
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [9:0]  idx;
        logic [31:0] data;
    } rd_vec_t;

    rd_vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic seen;

        vecs[0] = '{12'h008, 10'd2,    32'h2222_2222};
        vecs[1] = '{12'h00B, 10'd2,    32'h2222_2222};
        vecs[2] = '{12'h004, 10'd1,    32'h1111_1111};
        vecs[3] = '{12'h000, 10'd0,    32'h0000_0000};
        vecs[4] = '{12'hFFC, 10'd1023, 32'h3333_32EF};
        vecs[5] = '{12'h010, 10'd4,    32'h4444_4444};
        vecs[6] = '{12'h03D, 10'd15,   32'hFFFF_FFFF};

        // Hold reset with all valid inputs high. Every output must stay at 0.
        rstn = 1'b0;
        araddr = 12'h008; arvalid = 1'b1; rready = 1'b0;
        awaddr = 12'h020; awvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        wvalid = 1'b1; bready = 1'b0;
        araddr3 = '0; arvalid3 = 1'b0; rready3 = 1'b0;
        repeat (3) tick();
        check("rst arready", arready, 1'b0);
        check("rst rvalid", rvalid, 1'b0);
        check("rst rdata", rdata, 32'h0);
        check("rst rresp", rresp, 2'b00);
        check("rst awready", awready, 1'b0);
        check("rst wready", wready, 1'b0);
        check("rst bvalid", bvalid, 1'b0);
        check("rst bresp", bresp, 2'b00);
        check("rst rom_addr", rom_addr, 10'd0);
        rstn = 1'b1;
        tick();
        check("post-rst arready", arready, 1'b1);
        check("post-rst awready", awready, 1'b1);
        check("post-rst wready", wready, 1'b1);
        check("post-rst arready3", arready3, 1'b1);
        check("post-rst rvalid", rvalid, 1'b0);
        check("post-rst bvalid", bvalid, 1'b0);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        tick();

        // Table-driven reads. Byte-offset address bits must be ignored.
        for (int i = 0; i < 7; i++) begin
            do_read(vecs[i].addr, vecs[i].idx, vecs[i].data, $sformatf("vec%0d", i));
        end

        // Unaligned read, then stall rready for 5 cycles. The response must stay stable.
        wait_arready("stall");
        araddr = 12'h00B; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 10) begin tick(); n++; end
        check("stall latency", n, 2);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall rvalid", rvalid, 1'b1);
            check("stall rdata", rdata, 32'h2222_2222);
            check("stall arready", arready, 1'b0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("stall rvalid drop", rvalid, 1'b0);

        // Latency-3 instance: rvalid must rise 4 cycles after the AR handshake.
        araddr3 = 12'h010; arvalid3 = 1'b1;
        tick();
        arvalid3 = 1'b0;
        check("lat3 rom_addr", rom_addr3, 10'd4);
        n = 0;
        while (!rvalid3 && n < 12) begin tick(); n++; end
        check("lat3 latency", n, 4);
        check("lat3 rdata", rdata3, 32'h4444_4444);
        check("lat3 rresp", rresp3, 2'b00);
        rready3 = 1'b1;
        tick();
        rready3 = 1'b0;
        check("lat3 rvalid drop", rvalid3, 1'b0);

        // AW on cycle 0 and W on cycle 3, with a read running alongside.
        wait_arready("wr");
        awaddr = 12'h100; awvalid = 1'b1;
        araddr = 12'h010; arvalid = 1'b1;
        tick();                                   // edge 0: AW and AR accepted
        awvalid = 1'b0; arvalid = 1'b0;
        check("wr awready after AW", awready, 1'b0);
        check("wr wready before W", wready, 1'b1);
        check("wr bvalid early", bvalid, 1'b0);
        tick();                                   // edge 1
        check("wr bvalid e1", bvalid, 1'b0);
        tick();                                   // edge 2
        check("wr read rvalid", rvalid, 1'b1);
        check("wr read rdata", rdata, 32'h4444_4444);
        check("wr read rom_addr", rom_addr, 10'd4);
        check("wr bvalid e2", bvalid, 1'b0);
        rready = 1'b1;
        wdata = 32'hCAFE_F00D; wvalid = 1'b1;
        tick();                                   // edge 3: W accepted, R handshake
        wvalid = 1'b0; rready = 1'b0;
        check("wr bvalid", bvalid, 1'b1);
        check("wr bresp", bresp, 2'b10);
        check("wr wready after W", wready, 1'b0);
        check("wr awready hold", awready, 1'b0);
        check("wr rvalid drop", rvalid, 1'b0);
        check("wr rom_addr untouched", rom_addr, 10'd4);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("wr bvalid held", bvalid, 1'b1);
            check("wr bresp held", bresp, 2'b10);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("wr bvalid drop", bvalid, 1'b0);
        check("wr awready back", awready, 1'b1);
        check("wr wready back", wready, 1'b1);

        // AW and W in the same cycle.
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr2 bvalid", bvalid, 1'b1);
        check("wr2 bresp", bresp, 2'b10);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("wr2 bvalid drop", bvalid, 1'b0);

        // Reset in WAIT with a write pending. Nothing may be answered after release.
        wait_arready("rstwait");
        araddr = 12'h008; arvalid = 1'b1; awvalid = 1'b1;
        tick();                                   // AR accepted, read now in WAIT
        arvalid = 1'b0; awvalid = 1'b0;
        rstn = 1'b0;
        tick();
        check("rstwait rvalid in reset", rvalid, 1'b0);
        check("rstwait rom_addr in reset", rom_addr, 10'd0);
        rstn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rvalid || bvalid) seen = 1'b1;
        end
        check("rstwait no stale response", seen, 1'b0);
        check("rstwait awready", awready, 1'b1);
        do_read(12'h004, 10'd1, 32'h1111_1111, "after-rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
